mprj_enable_seq: RTL and testbench

- Power-up/power-down sequencer for the management-to-user-project interface.
- Consumes the constant-high tie-off vector from the logic-high tie-cell bank, one bit per interface group, plus the user-domain power-good.
- Produces staged enables for the Wishbone, logic-analyzer and IRQ groups; the downstream protection gating uses these enables.
- Enforces a stabilisation delay and an ordered bring-up and teardown, and flags any tie-off bit found low while the interface is active.

---
 rtl/mprj_enable_seq.sv | 190 +++++++++++++++++++
 tb/tb_mprj_enable_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mprj_enable_seq.sv
// mprj_enable_seq: staged power-up/power-down sequencer for the
// management-to-user-project interface groups (Wishbone, LA, IRQ).
module mprj_enable_seq #(
    parameter int unsigned STAB_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4
) (
    input  logic       core_clk,
    input  logic       resetb,
    input  logic [2:0] hi_tie,
    input  logic       user_pwrgood,
    input  logic       seq_en,
    input  logic       tie_fault_clr,
    output logic       en_wb,
    output logic       en_la,
    output logic       en_irq,
    output logic       seq_busy,
    output logic       seq_ready,
    output logic       tie_fault
);

    localparam int unsigned MAX_CNT = (STAB_CYCLES > STAGE_GAP) ? STAB_CYCLES : STAGE_GAP;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] STAB_LOAD = CNT_W'(STAB_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Stage register bit positions.
    localparam int unsigned ST_WB  = 0;
    localparam int unsigned ST_LA  = 1;
    localparam int unsigned ST_IRQ = 2;

    typedef enum logic [3:0] {
        IDLE,
        STAB,
        UP_WB,
        UP_LA,
        UP_IRQ,
        ON,
        DN_IRQ,
        DN_LA,
        DN_WB
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       stage_q, stage_d;
    logic             pg_meta_q, pg_sync_q;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;

    // Two-flop synchroniser for the asynchronous user-domain power-good.
    always_ff @(posedge core_clk) begin
        if (!resetb) begin
            pg_meta_q <= 1'b0;
            pg_sync_q <= 1'b0;
        end else begin
            pg_meta_q <= user_pwrgood;
            pg_sync_q <= pg_meta_q;
        end
    end

    // Sequencer state, counter, stage and status registers.
    always_ff @(posedge core_clk) begin
        if (!resetb) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            stage_q <= 3'b000;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    end

    // Next-state: power loss wins, then teardown request, then normal progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != CNT_ZERO) ? (cnt_q - CNT_ONE) : cnt_q;
        stage_d = stage_q;

        if (!pg_sync_q) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
            stage_d = 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (seq_en) begin
                        state_d = STAB;
                        cnt_d   = STAB_LOAD;
                    end
                end
                STAB: begin
                    if (!seq_en) begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_ZERO) begin
                        stage_d[ST_WB] = 1'b1;
                        cnt_d          = GAP_LOAD;
                        state_d        = UP_WB;
                    end
                end
                UP_WB: begin
                    if (!seq_en) begin
                        stage_d[ST_WB] = 1'b0;
                        cnt_d          = CNT_ZERO;
                        state_d        = DN_WB;
                    end else if (cnt_q == CNT_ZERO) begin
                        stage_d[ST_LA] = 1'b1;
                        cnt_d          = GAP_LOAD;
                        state_d        = UP_LA;
                    end
                end
                UP_LA: begin
                    if (!seq_en) begin
                        stage_d[ST_LA] = 1'b0;
                        cnt_d          = GAP_LOAD;
                        state_d        = DN_LA;
                    end else if (cnt_q == CNT_ZERO) begin
                        stage_d[ST_IRQ] = 1'b1;
                        cnt_d           = CNT_ZERO;
                        state_d         = ON;
                    end
                end
                ON: begin
                    if (!seq_en) begin
                        stage_d[ST_IRQ] = 1'b0;
                        cnt_d           = GAP_LOAD;
                        state_d         = DN_IRQ;
                    end
                end
                // DN_x: stage x has just been cleared; wait the gap, clear the next.
                DN_IRQ: begin
                    if (cnt_q == CNT_ZERO) begin
                        stage_d[ST_LA] = 1'b0;
                        cnt_d          = GAP_LOAD;
                        state_d        = DN_LA;
                    end
                end
                DN_LA: begin
                    if (cnt_q == CNT_ZERO) begin
                        stage_d[ST_WB] = 1'b0;
                        cnt_d          = CNT_ZERO;
                        state_d        = DN_WB;
                    end
                end
                DN_WB: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                    stage_d = 3'b000;
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they align with the stage edges.
    always_comb begin
        busy_d  = (state_d != IDLE) && (state_d != ON);
        ready_d = (state_d == ON);
        fault_d = fault_q;
        if (tie_fault_clr && (&hi_tie)) begin
            fault_d = 1'b0;
        end
        if ((state_q != IDLE) && !(&hi_tie)) begin
            fault_d = 1'b1;
        end
    end

    // Enables are qualified by the live tie-off bits.
    assign en_wb     = stage_q[ST_WB]  & hi_tie[0];
    assign en_la     = stage_q[ST_LA]  & hi_tie[1];
    assign en_irq    = stage_q[ST_IRQ] & hi_tie[2];
    assign seq_busy  = busy_q;
    assign seq_ready = ready_q;
    assign tie_fault = fault_q;

endmodule

// File: tb/tb_mprj_enable_seq.sv
// Testbench for mprj_enable_seq: default-parameter instance driven from a
// vector table, plus a minimum-timing instance driven by a hand-written sequence.
module tb_mprj_enable_seq;

    // Expected output word: {en_wb, en_la, en_irq, seq_busy, seq_ready, tie_fault}
    typedef struct {
        string       name;
        logic        rstb;
        logic        en;
        logic        pg;
        logic [2:0]  tie;
        logic        clr;
        int          hold;
        logic [5:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance.
    logic       a_rstb, a_pg, a_en, a_clr;
    logic [2:0] a_tie;
    logic       a_wb, a_la, a_irq, a_busy, a_ready, a_fault;

    // STAB_CYCLES=1, STAGE_GAP=1 instance.
    logic       b_rstb, b_pg, b_en, b_clr;
    logic [2:0] b_tie;
    logic       b_wb, b_la, b_irq, b_busy, b_ready, b_fault;

    mprj_enable_seq u_dut_a (
        .core_clk      (clk),
        .resetb        (a_rstb),
        .hi_tie        (a_tie),
        .user_pwrgood  (a_pg),
        .seq_en        (a_en),
        .tie_fault_clr (a_clr),
        .en_wb         (a_wb),
        .en_la         (a_la),
        .en_irq        (a_irq),
        .seq_busy      (a_busy),
        .seq_ready     (a_ready),
        .tie_fault     (a_fault)
    );

    mprj_enable_seq #(.STAB_CYCLES(1), .STAGE_GAP(1)) u_dut_b (
        .core_clk      (clk),
        .resetb        (b_rstb),
        .hi_tie        (b_tie),
        .user_pwrgood  (b_pg),
        .seq_en        (b_en),
        .tie_fault_clr (b_clr),
        .en_wb         (b_wb),
        .en_la         (b_la),
        .en_irq        (b_irq),
        .seq_busy      (b_busy),
        .seq_ready     (b_ready),
        .tie_fault     (b_fault)
    );

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input string n, input logic r, input logic e, input logic p,
                                input logic [2:0] t, input logic c, input int h,
                                input logic [5:0] x);
        vec_t v;
        v.name = n; v.rstb = r; v.en = e; v.pg = p;
        v.tie = t;  v.clr = c;  v.hold = h; v.exp = x;
        return v;
    endfunction

    // Drive one record, push its expectation, advance, then pop and compare.
    task automatic run_vec(input vec_t v, input bit sel);
        vec_t       r;
        logic [5:0] act;
        if (!sel) begin
            a_rstb = v.rstb; a_en = v.en; a_pg = v.pg; a_tie = v.tie; a_clr = v.clr;
        end else begin
            b_rstb = v.rstb; b_en = v.en; b_pg = v.pg; b_tie = v.tie; b_clr = v.clr;
        end
        sb.push_back(v);
        repeat (v.hold) @(posedge clk);
        #1;
        act = sel ? {b_wb, b_la, b_irq, b_busy, b_ready, b_fault}
                  : {a_wb, a_la, a_irq, a_busy, a_ready, a_fault};
        n_vec++;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL %s: scoreboard empty, got %b", v.name, act);
        end else begin
            r = sb.pop_front();
            if (act !== r.exp) begin
                n_miss++;
                $display("FAIL %s: got wb/la/irq/busy/ready/fault=%b want %b", r.name, act, r.exp);
            end
        end
    endtask

    initial begin
        a_rstb = 1'b0; a_en = 1'b0; a_pg = 1'b1; a_tie = 3'b111; a_clr = 1'b0;
        b_rstb = 1'b0; b_en = 1'b0; b_pg = 1'b1; b_tie = 3'b111; b_clr = 1'b0;

        //                name               rstb en  pg  tie     clr hold exp
        tbl.push_back(mk("reset",            0, 0, 1, 3'b111, 0,  2, 6'b000000));
        tbl.push_back(mk("idle_pg_sync",     1, 0, 1, 3'b111, 0,  3, 6'b000000));
        // Bring-up with default timing.
        tbl.push_back(mk("stab_entry",       1, 1, 1, 3'b111, 0,  1, 6'b000100));
        tbl.push_back(mk("stab_hold",        1, 1, 1, 3'b111, 0, 15, 6'b000100));
        tbl.push_back(mk("wb_rise",          1, 1, 1, 3'b111, 0,  1, 6'b100100));
        tbl.push_back(mk("wb_gap",           1, 1, 1, 3'b111, 0,  3, 6'b100100));
        tbl.push_back(mk("la_rise",          1, 1, 1, 3'b111, 0,  1, 6'b110100));
        tbl.push_back(mk("la_gap",           1, 1, 1, 3'b111, 0,  3, 6'b110100));
        tbl.push_back(mk("irq_ready",        1, 1, 1, 3'b111, 0,  1, 6'b111010));
        // Tie-off fault handling while ON.
        tbl.push_back(mk("tie_la_low",       1, 1, 1, 3'b101, 0,  1, 6'b101011));
        tbl.push_back(mk("tie_restored",     1, 1, 1, 3'b111, 0,  1, 6'b111011));
        tbl.push_back(mk("clr_while_fault",  1, 1, 1, 3'b101, 1,  1, 6'b101011));
        tbl.push_back(mk("clr_clean",        1, 1, 1, 3'b111, 1,  1, 6'b111010));
        // Ordered teardown; re-request mid-teardown must not abort it.
        tbl.push_back(mk("dn_irq",           1, 0, 1, 3'b111, 0,  1, 6'b110100));
        tbl.push_back(mk("dn_irq_gap",       1, 0, 1, 3'b111, 0,  3, 6'b110100));
        tbl.push_back(mk("dn_la",            1, 0, 1, 3'b111, 0,  1, 6'b100100));
        tbl.push_back(mk("dn_reen_gap",      1, 1, 1, 3'b111, 0,  3, 6'b100100));
        tbl.push_back(mk("dn_wb",            1, 1, 1, 3'b111, 0,  1, 6'b000100));
        tbl.push_back(mk("dn_idle",          1, 1, 1, 3'b111, 0,  1, 6'b000000));
        tbl.push_back(mk("restart_stab",     1, 1, 1, 3'b111, 0,  1, 6'b000100));
        tbl.push_back(mk("restart_on",       1, 1, 1, 3'b111, 0, 24, 6'b111010));
        // Power loss: two sync edges, then immediate unordered shutdown.
        tbl.push_back(mk("pg_drop_sync",     1, 1, 0, 3'b111, 0,  2, 6'b111010));
        tbl.push_back(mk("pg_drop_idle",     1, 1, 0, 3'b111, 0,  1, 6'b000000));
        tbl.push_back(mk("pg_low_tie_idle",  1, 1, 0, 3'b000, 0,  3, 6'b000000));
        tbl.push_back(mk("pg_back_sync",     1, 1, 1, 3'b111, 0,  2, 6'b000000));
        tbl.push_back(mk("pg_back_stab",     1, 1, 1, 3'b111, 0,  1, 6'b000100));
        // Abort from STAB and from UP_WB.
        tbl.push_back(mk("stab_abort",       1, 0, 1, 3'b111, 0,  1, 6'b000000));
        tbl.push_back(mk("stab_again",       1, 1, 1, 3'b111, 0,  1, 6'b000100));
        tbl.push_back(mk("upwb_reach",       1, 1, 1, 3'b111, 0, 17, 6'b100100));
        tbl.push_back(mk("upwb_abort",       1, 0, 1, 3'b111, 0,  1, 6'b000100));
        tbl.push_back(mk("upwb_idle",        1, 0, 1, 3'b111, 0,  1, 6'b000000));
        // Reset during UP_LA, then full restart.
        tbl.push_back(mk("t5_stab",          1, 1, 1, 3'b111, 0,  1, 6'b000100));
        tbl.push_back(mk("t5_upla",          1, 1, 1, 3'b111, 0, 21, 6'b110100));
        tbl.push_back(mk("t5_fault",         1, 1, 1, 3'b011, 0,  1, 6'b110101));
        tbl.push_back(mk("t5_reset",         0, 1, 1, 3'b111, 0,  1, 6'b000000));
        tbl.push_back(mk("t5_sync",          1, 1, 1, 3'b111, 0,  2, 6'b000000));
        tbl.push_back(mk("t5_stab2",         1, 1, 1, 3'b111, 0,  1, 6'b000100));
        tbl.push_back(mk("t5_wb",            1, 1, 1, 3'b111, 0, 16, 6'b100100));
        tbl.push_back(mk("t5_on",            1, 1, 1, 3'b111, 0,  8, 6'b111010));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], 1'b0);
        end

        // Minimum timing: stages on consecutive edges in both directions.
        run_vec(mk("b_reset",   0, 0, 1, 3'b111, 0, 2, 6'b000000), 1'b1);
        run_vec(mk("b_sync",    1, 0, 1, 3'b111, 0, 2, 6'b000000), 1'b1);
        run_vec(mk("b_stab",    1, 1, 1, 3'b111, 0, 1, 6'b000100), 1'b1);
        run_vec(mk("b_wb",      1, 1, 1, 3'b111, 0, 1, 6'b100100), 1'b1);
        run_vec(mk("b_la",      1, 1, 1, 3'b111, 0, 1, 6'b110100), 1'b1);
        run_vec(mk("b_irq",     1, 1, 1, 3'b111, 0, 1, 6'b111010), 1'b1);
        run_vec(mk("b_dn_irq",  1, 0, 1, 3'b111, 0, 1, 6'b110100), 1'b1);
        run_vec(mk("b_dn_la",   1, 0, 1, 3'b111, 0, 1, 6'b100100), 1'b1);
        run_vec(mk("b_dn_wb",   1, 0, 1, 3'b111, 0, 1, 6'b000100), 1'b1);
        run_vec(mk("b_idle",    1, 0, 1, 3'b111, 0, 1, 6'b000000), 1'b1);

        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d leftover entries want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
